sc_bkg_row_scroller: RTL and testbench

- Parametrised successor to the single-row background-type register. Holds one W-bit playfield row.
- Loads a level-dependent pattern from a transition/level index, with an optional OR-merge of a final-point mask.
- Scrolls (rotates) the row autonomously at a programmable rate instead of shifting once per external request.
- Sits between the level controller FSM and the matrix/VGA row mux. One instance per playfield row.

---
 rtl/sc_bkg_pkg.sv | 39 +++
 rtl/sc_bkg_tick_div.sv | 37 +++
 rtl/sc_bkg_row_scroller.sv | 154 +++++++++++++++
 tb/tb_sc_bkg_row_scroller.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sc_bkg_pkg.sv
// Shared definitions for the background-row scroller family: level indices,
// scroll directions, FSM encoding and the default 8-bit pattern table.
package sc_bkg_pkg;

  localparam int unsigned IDX_START = 0;
  localparam int unsigned IDX_T1    = 1;
  localparam int unsigned IDX_L1    = 2;
  localparam int unsigned IDX_T2    = 3;
  localparam int unsigned IDX_L2    = 4;
  localparam int unsigned IDX_T3    = 5;
  localparam int unsigned IDX_L3    = 6;
  localparam int unsigned IDX_T4    = 7;
  localparam int unsigned IDX_L4    = 8;
  localparam int unsigned IDX_WIN   = 9;
  localparam int unsigned NUM_PATTERNS = 10;

  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Entry i occupies bits [i*8 +: 8]; START sits in the low byte.
  localparam logic [79:0] PATTERN_TABLE_DEFAULT = {
    8'hAA,  // WIN
    8'h5A,  // L4
    8'hFF,  // T4
    8'h66,  // L3
    8'hE7,  // T3
    8'h3C,  // L2
    8'hC3,  // T2
    8'h18,  // L1
    8'h81,  // T1
    8'h24   // START
  };

endpackage

// File: rtl/sc_bkg_tick_div.sv
// Programmable period divider: counts while enabled, pulses tc_o when the
// count equals period_i, then restarts from zero. Holds its count when disabled.
module sc_bkg_tick_div #(
  parameter int unsigned SPEED_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [SPEED_W-1:0] period_i,
  output logic               tc_o
);

  logic [SPEED_W-1:0] cnt_q;
  logic [SPEED_W-1:0] cnt_d;

  assign tc_o = (cnt_q == period_i);

  // A period lowered below the current count lets the counter wrap through 2^SPEED_W.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sc_bkg_row_scroller.sv
// One playfield background row: level-pattern loads plus autonomous scrolling.
// Define SC_BKG_ROW_BOUNCE_EN for reflecting shifts instead of rotation.
module sc_bkg_row_scroller
  import sc_bkg_pkg::*;
#(
  parameter int unsigned                 DATAWIDTH     = 8,
  parameter int unsigned                 LEVEL_W       = 4,
  parameter int unsigned                 SPEED_W       = 8,
  parameter logic [DATAWIDTH-1:0]        CLEAR_PATTERN = '0,
  parameter logic [10*DATAWIDTH-1:0]     PATTERN_TABLE = PATTERN_TABLE_DEFAULT
) (
  input  logic                 SC_LastRegBACKGTYPE_CLOCK_50,
  input  logic                 SC_LastRegBACKGTYPE_RESET_InHigh,
  input  logic                 clear_InLow,
  input  logic                 load_InLow,
  input  logic                 loadfinal_InLow,
  input  logic                 run_In,
  input  logic [1:0]           dir_In,
  input  logic [SPEED_W-1:0]   speed_InBUS,
  input  logic [LEVEL_W-1:0]   level_InBUS,
  input  logic [DATAWIDTH-1:0] lastpoint_InBUS,
  output logic [DATAWIDTH-1:0] data_OutBUS,
  output logic                 shift_pulse_Out,
  output logic                 busy_Out
);

  state_e               state_q;
  logic [DATAWIDTH-1:0] row_q;
  logic [DATAWIDTH-1:0] row_d;
  logic                 pulse_q;
  logic                 busy_q;
  logic                 moved;
  logic                 load_any;
  logic                 tick_en;
  logic                 tc;
  logic                 scroll;
  logic [DATAWIDTH-1:0] pattern;
  logic [31:0]          level_idx;

`ifdef SC_BKG_ROW_BOUNCE_EN
  logic [1:0]           dir_q;
  logic [1:0]           dir_d;
`endif

  assign level_idx = 32'(level_InBUS);

  always_comb begin
    pattern = '0;
    for (int unsigned i = 0; i < NUM_PATTERNS; i++) begin
      if (level_idx == i) begin
        pattern = PATTERN_TABLE[i*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  assign load_any = ~clear_InLow | ~load_InLow | ~loadfinal_InLow;
  // Counting pauses as soon as run_In drops so re-entry resumes on the same phase.
  assign tick_en  = (state_q == ST_RUN) & run_In & ~load_any;
  assign scroll   = tick_en & tc;

  sc_bkg_tick_div #(
    .SPEED_W (SPEED_W)
  ) u_tick_div (
    .clk_i    (SC_LastRegBACKGTYPE_CLOCK_50),
    .rst_i    (SC_LastRegBACKGTYPE_RESET_InHigh),
    .clr_i    (load_any),
    .en_i     (tick_en),
    .period_i (speed_InBUS),
    .tc_o     (tc)
  );

  always_comb begin
    row_d = row_q;
    moved = 1'b0;
`ifdef SC_BKG_ROW_BOUNCE_EN
    dir_d = load_any ? dir_In : dir_q;
`endif
    if (!clear_InLow) begin
      row_d = CLEAR_PATTERN;
    end else if (!load_InLow) begin
      row_d = pattern;
    end else if (!loadfinal_InLow) begin
      row_d = pattern | lastpoint_InBUS;
    end else if (scroll) begin
`ifdef SC_BKG_ROW_BOUNCE_EN
      // Hitting an edge costs one scroll slot: the row stays and only the direction flips.
      if (dir_q == DIR_LEFT) begin
        if (row_q[DATAWIDTH-1]) begin
          dir_d = DIR_RIGHT;
        end else begin
          row_d = {row_q[DATAWIDTH-2:0], 1'b0};
          moved = 1'b1;
        end
      end else if (dir_q == DIR_RIGHT) begin
        if (row_q[0]) begin
          dir_d = DIR_LEFT;
        end else begin
          row_d = {1'b0, row_q[DATAWIDTH-1:1]};
          moved = 1'b1;
        end
      end
`else
      if (dir_In == DIR_LEFT) begin
        row_d = {row_q[DATAWIDTH-2:0], row_q[DATAWIDTH-1]};
        moved = 1'b1;
      end else if (dir_In == DIR_RIGHT) begin
        row_d = {row_q[0], row_q[DATAWIDTH-1:1]};
        moved = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge SC_LastRegBACKGTYPE_CLOCK_50 or posedge SC_LastRegBACKGTYPE_RESET_InHigh) begin
    if (SC_LastRegBACKGTYPE_RESET_InHigh) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SC_BKG_ROW_BOUNCE_EN
      dir_q   <= DIR_LEFT;
`endif
    end else begin
      row_q   <= row_d;
      pulse_q <= moved;
`ifdef SC_BKG_ROW_BOUNCE_EN
      dir_q   <= dir_d;
`endif
      case (state_q)
        ST_IDLE: begin
          if (run_In) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!run_In) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_OutBUS     = row_q;
  assign shift_pulse_Out = pulse_q;
  assign busy_Out        = busy_q;

endmodule

// File: tb/tb_sc_bkg_row_scroller.sv
// Directed bench for sc_bkg_row_scroller (default 8-bit table); the bounce
// section is selected with SC_BKG_ROW_BOUNCE_EN to match the RTL build.
module tb_sc_bkg_row_scroller;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear_n;
  logic       load_n;
  logic       loadfinal_n;
  logic       run;
  logic [1:0] dir;
  logic [7:0] speed;
  logic [3:0] level;
  logic [7:0] lastpoint;
  logic [7:0] data;
  logic       pulse;
  logic       busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sc_bkg_row_scroller #(
    .DATAWIDTH (8),
    .LEVEL_W   (4),
    .SPEED_W   (8)
  ) dut (
    .SC_LastRegBACKGTYPE_CLOCK_50     (clk),
    .SC_LastRegBACKGTYPE_RESET_InHigh (rst),
    .clear_InLow                      (clear_n),
    .load_InLow                       (load_n),
    .loadfinal_InLow                  (loadfinal_n),
    .run_In                           (run),
    .dir_In                           (dir),
    .speed_InBUS                      (speed),
    .level_InBUS                      (level),
    .lastpoint_InBUS                  (lastpoint),
    .data_OutBUS                      (data),
    .shift_pulse_Out                  (pulse),
    .busy_Out                         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

`ifdef SC_BKG_ROW_BOUNCE_EN
  logic [7:0] b_data  [11] = '{8'h80, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08,
                               8'h04, 8'h02, 8'h01, 8'h01, 8'h02};
  logic       b_pulse [11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                               1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`else
  logic [7:0] rot_exp [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
  logic [7:0] cur;
  int         pulses;
`endif

  initial begin
    rst = 1'b1; clear_n = 1'b1; load_n = 1'b1; loadfinal_n = 1'b1;
    run = 1'b0; dir = 2'b01; speed = 8'd3; level = 4'd0; lastpoint = 8'h00;
    step(2);
    chk("rst_data", data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pulse", pulse, 1'b0);
    rst = 1'b0;

    level = 4'd1; load_n = 1'b0; step(1); load_n = 1'b1;
    chk("load_t1", data, 8'h81);
    clear_n = 1'b0; load_n = 1'b0; step(1); clear_n = 1'b1; load_n = 1'b1;
    chk("clear_over_load", data, 8'h00);
    level = 4'd2; load_n = 1'b0; step(1); load_n = 1'b1;
    chk("load_l1", data, 8'h18);
    level = 4'd9; load_n = 1'b0; step(1); load_n = 1'b1;
    chk("load_win", data, 8'hAA);
    level = 4'd12; load_n = 1'b0; step(1); load_n = 1'b1;
    chk("load_oor", data, 8'h00);
    level = 4'd0; lastpoint = 8'h81; loadfinal_n = 1'b0; step(1); loadfinal_n = 1'b1;
    chk("loadfinal", data, 8'hA5);
    load_n = 1'b0; loadfinal_n = 1'b0; step(1); load_n = 1'b1; loadfinal_n = 1'b1;
    chk("load_over_final", data, 8'h24);

    // Reset while running with A5 loaded.
    loadfinal_n = 1'b0; speed = 8'd200; run = 1'b1; step(1); loadfinal_n = 1'b1;
    chk("run_a5_data", data, 8'hA5);
    chk("run_a5_busy", busy, 1'b1);
    step(1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_data", data, 8'h00);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_pulse", pulse, 1'b0);
    run = 1'b0;
    step(1);
    rst = 1'b0;

`ifndef SC_BKG_ROW_BOUNCE_EN
    level = 4'd12; lastpoint = 8'h01; loadfinal_n = 1'b0; step(1); loadfinal_n = 1'b1;
    chk("final_oor", data, 8'h01);
    speed = 8'd3; dir = 2'b01; run = 1'b1;
    step(1);
    chk("enter_busy", busy, 1'b1);
    cur = 8'h01;
    for (int m = 0; m < 8; m++) begin
      for (int j = 0; j < 3; j++) begin
        step(1);
        chk("rotl_wait_data", data, cur);
        chk("rotl_wait_pulse", pulse, 1'b0);
      end
      step(1);
      cur = rot_exp[m];
      chk("rotl_data", data, cur);
      chk("rotl_pulse", pulse, 1'b1);
    end

    step(2);
    chk("pre_pause", data, 8'h01);
    run = 1'b0;
    step(1);
    chk("pause_busy", busy, 1'b0);
    step(9);
    chk("pause_data", data, 8'h01);
    chk("pause_pulse", pulse, 1'b0);
    run = 1'b1;
    step(1);
    chk("resume_busy", busy, 1'b1);
    chk("resume_data", data, 8'h01);
    step(1);
    chk("resume_tick_data", data, 8'h01);
    chk("resume_tick_pulse", pulse, 1'b0);
    step(1);
    chk("resume_shift_data", data, 8'h02);
    chk("resume_shift_pulse", pulse, 1'b1);

    dir = 2'b11; pulses = 0;
    repeat (8) begin
      step(1);
      pulses += int'(pulse);
    end
    chk("hold_pulses", pulses, 0);
    chk("hold_data", data, 8'h02);

    lastpoint = 8'h02; loadfinal_n = 1'b0; speed = 8'd0; dir = 2'b10;
    step(1); loadfinal_n = 1'b1;
    chk("reload_data", data, 8'h02);
    chk("reload_pulse", pulse, 1'b0);
    step(1);
    chk("rotr0_data", data, 8'h01);
    chk("rotr0_pulse", pulse, 1'b1);
    step(1);
    chk("rotr1_data", data, 8'h80);
    step(1);
    chk("rotr2_data", data, 8'h40);
    chk("rotr2_pulse", pulse, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("pend_rst_pulse", pulse, 1'b0);
    chk("pend_rst_data", data, 8'h00);
    chk("pend_rst_busy", busy, 1'b0);
    step(1);
    rst = 1'b0;
`else
    dir = 2'b01; level = 4'd12; lastpoint = 8'h40; speed = 8'd0;
    loadfinal_n = 1'b0; run = 1'b1;
    step(1);
    loadfinal_n = 1'b1; dir = 2'b10;
    chk("bounce_load", data, 8'h40);
    chk("bounce_busy", busy, 1'b1);
    for (int k = 0; k < 11; k++) begin
      step(1);
      chk("bounce_data", data, b_data[k]);
      chk("bounce_pulse", pulse, b_pulse[k]);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
